// File: rtl/vga_frame_sniffer_if.sv
// -----------------------------------------------------------------------------
// vga_frame_sniffer_if
// Bundles the video tap and the result read port of vga_frame_sniffer.
//   master : video source / register reader (drives video and rd_en/rd_addr)
//   slave  : the sniffer (returns rd_data/rd_valid and status flags)
// Signals:
//   polarity          0 = syncs active-low, 1 = syncs active-high
//   hsync, vsync      raw sync inputs
//   visible           data enable
//   r, g, b           2-bit colour components
//   rd_en, rd_addr    one-cycle read strobe and 3-bit result select
//   rd_data, rd_valid read data and its one-cycle valid pulse
//   locked            at least one full frame measured
//   frame_done        one-cycle pulse when frame results are latched
//   err               line-length mismatch in last latched frame
// -----------------------------------------------------------------------------
interface vga_frame_sniffer_if;
   logic        polarity;
   logic        hsync;
   logic        vsync;
   logic        visible;
   logic [1:0]  r;
   logic [1:0]  g;
   logic [1:0]  b;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        locked;
   logic        frame_done;
   logic        err;

   modport master (
      output polarity, hsync, vsync, visible, r, g, b, rd_en, rd_addr,
      input  rd_data, rd_valid, locked, frame_done, err
   );

   modport slave (
      input  polarity, hsync, vsync, visible, r, g, b, rd_en, rd_addr,
      output rd_data, rd_valid, locked, frame_done, err
   );
endinterface

// File: rtl/vga_frame_sniffer.sv
// -----------------------------------------------------------------------------
// vga_frame_sniffer
// Receive-side video monitor. Registers hsync/vsync/visible/RGB once, measures
// line length, line count, active width/height and a CRC-16-CCITT over the
// visible pixels of each frame, and latches the results into shadow registers
// on every vsync leading edge after the first one.
// Ports:
//   clk    pixel clock
//   reset  synchronous, active-high reset
//   bus    vga_frame_sniffer_if.slave (video inputs, read port, status)
// Read map: 0 h_total, 1 v_total, 2 act_w, 3 act_h, 4 crc, 5 frame_cnt,
//           6 {14'b0, err, locked}, 7 zero.
// -----------------------------------------------------------------------------
module vga_frame_sniffer #(
   parameter int unsigned CNT_W    = 12,
   parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
   input logic                clk,
   input logic                reset,
   vga_frame_sniffer_if.slave bus
);

   localparam int unsigned      PAD_W    = 16 - CNT_W;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [0:0] {ST_SEARCH = 1'b0, ST_MEASURE = 1'b1} state_t;

   // Saturating increment: counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // CRC-16-CCITT (poly 0x1021) over one 6-bit pixel, r[1] shifted in first.
   function automatic logic [15:0] crc6(input logic [15:0] crc_in, input logic [5:0] px);
      logic [15:0] c;
      c = crc_in;
      for (int i = 5; i >= 0; i--) begin
         if (c[15] ^ px[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else               c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   state_t           state_r;
   logic             hsync_q_r, vsync_q_r, visible_q_r, hs_prev_r, vs_prev_r;
   logic [5:0]       pix_q_r;
   logic [CNT_W-1:0] hcnt_r, line_len_r, lines_r, act_px_r, ref_px_r, act_lines_r;
   logic             ref_set_r, err_live_r;
   logic [15:0]      crc_r;
   logic [CNT_W-1:0] h_total_r, v_total_r, act_w_r, act_h_r;
   logic [15:0]      crc_sh_r, frame_cnt_r, rd_data_r;
   logic             err_r, locked_r, frame_done_r, rd_valid_r;

   logic             hs_a_s, vs_a_s, hs_edge_s, vs_edge_s;
   logic [CNT_W-1:0] hcnt_nxt_s, line_len_nxt_s, lines_nxt_s, act_px_nxt_s;
   logic [CNT_W-1:0] ref_px_nxt_s, act_lines_nxt_s;
   logic             ref_set_nxt_s, err_live_nxt_s;
   logic [15:0]      crc_nxt_s, rd_mux_s;

   assign hs_a_s    = ~(hsync_q_r ^ bus.polarity);
   assign vs_a_s    = ~(vsync_q_r ^ bus.polarity);
   assign hs_edge_s = hs_a_s & ~hs_prev_r;
   assign vs_edge_s = vs_a_s & ~vs_prev_r;

   // Live measurement next-state; also what a closing frame latches, so a
   // line edge coincident with the vsync edge is counted in that frame.
   always_comb begin
      hcnt_nxt_s      = sat_inc(hcnt_r);
      line_len_nxt_s  = line_len_r;
      lines_nxt_s     = lines_r;
      act_px_nxt_s    = act_px_r;
      ref_px_nxt_s    = ref_px_r;
      ref_set_nxt_s   = ref_set_r;
      act_lines_nxt_s = act_lines_r;
      err_live_nxt_s  = err_live_r;
      crc_nxt_s       = crc_r;
      if (visible_q_r) begin
         act_px_nxt_s = sat_inc(act_px_r);
         crc_nxt_s    = crc6(crc_r, pix_q_r);
      end else begin
         act_px_nxt_s = act_px_r;
      end
      if (hs_edge_s) begin
         // The edge cycle already belongs to the new line.
         hcnt_nxt_s     = CNT_ONE;
         line_len_nxt_s = hcnt_r;
         lines_nxt_s    = sat_inc(lines_r);
         act_px_nxt_s   = visible_q_r ? CNT_ONE : CNT_ZERO;
         if (act_px_r != CNT_ZERO) begin
            act_lines_nxt_s = sat_inc(act_lines_r);
            if (!ref_set_r) begin
               ref_px_nxt_s  = act_px_r;
               ref_set_nxt_s = 1'b1;
            end else if (act_px_r != ref_px_r) begin
               err_live_nxt_s = 1'b1;
            end else begin
               err_live_nxt_s = err_live_r;
            end
         end else begin
            act_lines_nxt_s = act_lines_r;
         end
      end else begin
         line_len_nxt_s = line_len_r;
      end
   end

   // Result select for the read port (values zero-extended to 16 bits).
   always_comb begin
      case (bus.rd_addr)
         3'd0:    rd_mux_s = {{PAD_W{1'b0}}, h_total_r};
         3'd1:    rd_mux_s = {{PAD_W{1'b0}}, v_total_r};
         3'd2:    rd_mux_s = {{PAD_W{1'b0}}, act_w_r};
         3'd3:    rd_mux_s = {{PAD_W{1'b0}}, act_h_r};
         3'd4:    rd_mux_s = crc_sh_r;
         3'd5:    rd_mux_s = frame_cnt_r;
         3'd6:    rd_mux_s = {14'b0, err_r, locked_r};
         default: rd_mux_s = 16'h0000;
      endcase
   end

   // Input stage, SEARCH/MEASURE FSM, live counters, shadow latch and read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync_q_r    <= ~bus.polarity;
         vsync_q_r    <= ~bus.polarity;
         visible_q_r  <= 1'b0;
         pix_q_r      <= 6'h00;
         hs_prev_r    <= 1'b0;
         vs_prev_r    <= 1'b0;
         state_r      <= ST_SEARCH;
         hcnt_r       <= CNT_ZERO;
         line_len_r   <= CNT_ZERO;
         lines_r      <= CNT_ZERO;
         act_px_r     <= CNT_ZERO;
         ref_px_r     <= CNT_ZERO;
         ref_set_r    <= 1'b0;
         act_lines_r  <= CNT_ZERO;
         err_live_r   <= 1'b0;
         crc_r        <= CRC_INIT;
         h_total_r    <= CNT_ZERO;
         v_total_r    <= CNT_ZERO;
         act_w_r      <= CNT_ZERO;
         act_h_r      <= CNT_ZERO;
         crc_sh_r     <= 16'h0000;
         frame_cnt_r  <= 16'h0000;
         err_r        <= 1'b0;
         locked_r     <= 1'b0;
         frame_done_r <= 1'b0;
         rd_data_r    <= 16'h0000;
         rd_valid_r   <= 1'b0;
      end else begin
         hsync_q_r    <= bus.hsync;
         vsync_q_r    <= bus.vsync;
         visible_q_r  <= bus.visible;
         pix_q_r      <= {bus.r, bus.g, bus.b};
         hs_prev_r    <= hs_a_s;
         vs_prev_r    <= vs_a_s;
         frame_done_r <= 1'b0;
         case (state_r)
            ST_SEARCH: begin
               state_r <= vs_edge_s ? ST_MEASURE : ST_SEARCH;
            end
            ST_MEASURE: begin
               state_r <= ST_MEASURE;
               if (vs_edge_s) begin
                  h_total_r    <= line_len_nxt_s;
                  v_total_r    <= lines_nxt_s;
                  act_w_r      <= ref_px_nxt_s;
                  act_h_r      <= act_lines_nxt_s;
                  crc_sh_r     <= crc_r;
                  err_r        <= err_live_nxt_s;
                  frame_cnt_r  <= frame_cnt_r + 16'd1;
                  frame_done_r <= 1'b1;
                  locked_r     <= 1'b1;
               end
            end
            default: state_r <= ST_SEARCH;
         endcase
         if (vs_edge_s) begin
            // New frame starts on the edge cycle itself.
            hcnt_r      <= CNT_ONE;
            line_len_r  <= CNT_ZERO;
            lines_r     <= CNT_ZERO;
            act_px_r    <= visible_q_r ? CNT_ONE : CNT_ZERO;
            ref_px_r    <= CNT_ZERO;
            ref_set_r   <= 1'b0;
            act_lines_r <= CNT_ZERO;
            err_live_r  <= 1'b0;
            crc_r       <= visible_q_r ? crc6(CRC_INIT, pix_q_r) : CRC_INIT;
         end else if (state_r == ST_MEASURE) begin
            hcnt_r      <= hcnt_nxt_s;
            line_len_r  <= line_len_nxt_s;
            lines_r     <= lines_nxt_s;
            act_px_r    <= act_px_nxt_s;
            ref_px_r    <= ref_px_nxt_s;
            ref_set_r   <= ref_set_nxt_s;
            act_lines_r <= act_lines_nxt_s;
            err_live_r  <= err_live_nxt_s;
            crc_r       <= crc_nxt_s;
         end
         // Mux sees pre-latch shadows, so a read coincident with a latch is old.
         rd_valid_r <= bus.rd_en;
         if (bus.rd_en) rd_data_r <= rd_mux_s;
      end
   end

   assign bus.rd_data    = rd_data_r;
   assign bus.rd_valid   = rd_valid_r;
   assign bus.locked     = locked_r;
   assign bus.frame_done = frame_done_r;
   assign bus.err        = err_r;

endmodule

// File: tb/tb_vga_frame_sniffer.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_sniffer
// Directed bench for vga_frame_sniffer. The source is a 20x10 raster with
// hsync active for x<2, vsync active for y<2 and a 12x6 visible window at
// x=4..15, y=2..7, carrying solid pixel 6'h3F. Inputs change on the falling
// edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_frame_sniffer;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   int   fd_count;

   vga_frame_sniffer_if vif();

   vga_frame_sniffer #(.CNT_W(12), .CRC_INIT(16'hFFFF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (vif.frame_done === 1'b1) fd_count++;

   // Reference CRC-16-CCITT seeded 0xFFFF over npix copies of a 6-bit pixel.
   function automatic logic [15:0] model_crc(input int npix, input logic [5:0] p);
      logic [15:0] c;
      logic        msb;
      c = 16'hFFFF;
      for (int n = 0; n < npix; n++) begin
         for (int k = 5; k >= 0; k--) begin
            msb = c[15];
            c   = c << 1;
            if (msb ^ p[k]) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   task automatic idle_inputs();
      vif.hsync   = ~vif.polarity;
      vif.vsync   = ~vif.polarity;
      vif.visible = 1'b0;
      vif.r = 2'b00; vif.g = 2'b00; vif.b = 2'b00;
      vif.rd_en   = 1'b0;
      vif.rd_addr = 3'd0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         idle_inputs();
      end
   endtask

   // One raster clock at (x,y); nvis = visible pixels on this line.
   task automatic pix(input int x, input int y, input int nvis);
      logic hs, vs, vis;
      @(negedge clk);
      hs  = (x < 2);
      vs  = (y < 2);
      vis = (y >= 2) && (y < 8) && (x >= 4) && (x < 4 + nvis);
      vif.hsync   = vif.polarity ? hs : ~hs;
      vif.vsync   = vif.polarity ? vs : ~vs;
      vif.visible = vis;
      vif.r = vis ? 2'b11 : 2'b00;
      vif.g = vis ? 2'b11 : 2'b00;
      vif.b = vis ? 2'b11 : 2'b00;
      vif.rd_en = 1'b0;
   endtask

   task automatic drive_lines(input int y0, input int y1, input int bad_y);
      for (int y = y0; y <= y1; y++)
         for (int x = 0; x < 20; x++)
            pix(x, y, (y == bad_y) ? 11 : 12);
   endtask

   task automatic drive_frame(input int bad_y);
      drive_lines(0, 9, bad_y);
   endtask

   task automatic do_read(input logic [2:0] addr, output logic [15:0] data, output logic valid);
      @(negedge clk);
      idle_inputs();
      vif.rd_en   = 1'b1;
      vif.rd_addr = addr;
      @(negedge clk);
      vif.rd_en = 1'b0;
      data  = vif.rd_data;
      valid = vif.rd_valid;
   endtask

   task automatic apply_reset(input logic p);
      @(negedge clk);
      reset = 1'b1;
      vif.polarity = p;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      logic        v;
      apply_reset(1'b1);
      vectors++; if (vif.locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", vif.locked); end
      vectors++; if (vif.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", vif.err); end
      vectors++; if (vif.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", vif.frame_done); end
      vectors++; if ({vif.rd_valid, vif.rd_data} !== 17'h0) begin miscompares++; $display("FAIL reset_rd: got %b/%h want 0/0000", vif.rd_valid, vif.rd_data); end
      for (int a = 0; a < 8; a++) begin
         do_read(3'(a), d, v);
         vectors++; if ({v, d} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL reset_read%0d: got %b/%h want 1/0000", a, v, d); end
      end
   endtask

   task automatic test_solid_frames(input logic p);
      logic [15:0] exp_tab [8];
      logic [15:0] d;
      logic        v;
      int          fd0;
      exp_tab[0] = 16'd20; exp_tab[1] = 16'd10; exp_tab[2] = 16'd12; exp_tab[3] = 16'd6;
      exp_tab[4] = model_crc(72, 6'h3F);
      exp_tab[5] = 16'd2;  exp_tab[6] = 16'h0001; exp_tab[7] = 16'h0000;
      apply_reset(p);
      fd0 = fd_count;
      for (int f = 0; f < 3; f++) drive_frame(-1);
      idle(3);
      vectors++; if (fd_count - fd0 !== 2) begin miscompares++; $display("FAIL pol%0b_frame_done_count: got %0d want 2", p, fd_count - fd0); end
      vectors++; if (vif.locked !== 1'b1) begin miscompares++; $display("FAIL pol%0b_locked: got %b want 1", p, vif.locked); end
      for (int a = 0; a < 8; a++) begin
         do_read(3'(a), d, v);
         vectors++; if ({v, d} !== {1'b1, exp_tab[a]}) begin miscompares++; $display("FAIL pol%0b_read%0d: got %b/%h want 1/%h", p, a, v, d, exp_tab[a]); end
      end
   endtask

   task automatic test_line_error();
      logic [15:0] d;
      logic        v;
      apply_reset(1'b1);
      drive_frame(-1);
      drive_frame(4);
      drive_frame(-1);
      do_read(3'd6, d, v);
      vectors++; if ({v, d} !== {1'b1, 16'h0003}) begin miscompares++; $display("FAIL err_status: got %b/%h want 1/0003", v, d); end
      vectors++; if (vif.err !== 1'b1) begin miscompares++; $display("FAIL err_pin: got %b want 1", vif.err); end
      do_read(3'd2, d, v);
      vectors++; if (d !== 16'd12) begin miscompares++; $display("FAIL err_act_w: got %0d want 12", d); end
      drive_frame(-1);
      do_read(3'd6, d, v);
      vectors++; if ({v, d} !== {1'b1, 16'h0001}) begin miscompares++; $display("FAIL err_clear_status: got %b/%h want 1/0001", v, d); end
      vectors++; if (vif.err !== 1'b0) begin miscompares++; $display("FAIL err_clear_pin: got %b want 0", vif.err); end
   endtask

   task automatic test_read_at_latch();
      apply_reset(1'b1);
      drive_frame(-1);
      pix(0, 0, 12);
      pix(1, 0, 12);
      vif.rd_en = 1'b1; vif.rd_addr = 3'd5;
      pix(2, 0, 12);
      vectors++; if ({vif.frame_done, vif.rd_valid, vif.rd_data} !== {1'b1, 1'b1, 16'd0}) begin miscompares++; $display("FAIL latch_read_old: got fd=%b v=%b d=%h want 1/1/0000", vif.frame_done, vif.rd_valid, vif.rd_data); end
      vif.rd_en = 1'b1; vif.rd_addr = 3'd5;
      pix(3, 0, 12);
      vectors++; if ({vif.frame_done, vif.rd_valid, vif.rd_data} !== {1'b0, 1'b1, 16'd1}) begin miscompares++; $display("FAIL latch_read_new: got fd=%b v=%b d=%h want 0/1/0001", vif.frame_done, vif.rd_valid, vif.rd_data); end
      pix(4, 0, 12);
      vectors++; if ({vif.rd_valid, vif.rd_data} !== {1'b0, 16'd1}) begin miscompares++; $display("FAIL latch_read_hold: got v=%b d=%h want 0/0001", vif.rd_valid, vif.rd_data); end
      for (int x = 5; x < 20; x++) pix(x, 0, 12);
      drive_lines(1, 9, -1);
   endtask

   task automatic test_saturation();
      logic [15:0] d;
      logic        v;
      apply_reset(1'b1);
      drive_frame(-1);
      drive_lines(0, 1, -1);
      idle(5000);
      drive_frame(-1);
      do_read(3'd0, d, v);
      vectors++; if (d !== 16'd4095) begin miscompares++; $display("FAIL sat_h_total: got %0d want 4095", d); end
      do_read(3'd1, d, v);
      vectors++; if (d !== 16'd2) begin miscompares++; $display("FAIL sat_v_total: got %0d want 2", d); end
      do_read(3'd6, d, v);
      vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL sat_status: got %h want 0001", d); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] d;
      logic        v;
      int          fd0;
      apply_reset(1'b1);
      drive_frame(-1);
      drive_frame(-1);
      drive_lines(0, 4, -1);
      vectors++; if (vif.locked !== 1'b1) begin miscompares++; $display("FAIL mid_locked_before: got %b want 1", vif.locked); end
      apply_reset(1'b1);
      vectors++; if (vif.locked !== 1'b0) begin miscompares++; $display("FAIL mid_locked_after: got %b want 0", vif.locked); end
      for (int a = 0; a < 8; a++) begin
         do_read(3'(a), d, v);
         vectors++; if ({v, d} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL mid_read%0d: got %b/%h want 1/0000", a, v, d); end
      end
      fd0 = fd_count;
      drive_frame(-1);
      vectors++; if (fd_count !== fd0) begin miscompares++; $display("FAIL mid_first_edge: got %0d pulses want 0", fd_count - fd0); end
      drive_frame(-1);
      vectors++; if (fd_count !== fd0 + 1) begin miscompares++; $display("FAIL mid_second_edge: got %0d pulses want 1", fd_count - fd0); end
      do_read(3'd0, d, v);
      vectors++; if (d !== 16'd20) begin miscompares++; $display("FAIL mid_h_total: got %0d want 20", d); end
      do_read(3'd5, d, v);
      vectors++; if (d !== 16'd1) begin miscompares++; $display("FAIL mid_frame_cnt: got %0d want 1", d); end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      fd_count     = 0;
      reset        = 1'b1;
      vif.polarity = 1'b1;
      idle_inputs();
      test_reset();
      test_solid_frames(1'b1);
      test_solid_frames(1'b0);
      test_line_error();
      test_read_at_latch();
      test_saturation();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
